// File: rtl/or1k_dpram_port_requester.sv
// Initiator-side front end for one port of a single-clock true dual-port RAM.
// A valid/ready request channel drives the RAM port directly. The RAM's
// registered dout is captured one cycle later into a small in-order response
// FIFO. Requests are only accepted when a FIFO slot is guaranteed, so
// backpressure on the response side never drops RAM data.
module or1k_dpram_port_requester #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // request channel
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  // response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_we,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  // RAM port
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;   // holds 0..RSP_DEPTH
  localparam int CR_W  = CNT_W + 1;   // holds count + inflight without wrap
  localparam logic [CR_W-1:0]  DEPTH_CR  = CR_W'(RSP_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RSP_DEPTH);

  typedef struct packed {
    logic                  we;
    logic [DATA_WIDTH-1:0] data;
  } rsp_entry_t;

  rsp_entry_t       buf_q [RSP_DEPTH];
  rsp_entry_t       buf_d [RSP_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             inflight_q, inflight_d;
  logic             we_q, we_d;

  logic             issue;
  logic             pop;
  logic             push;
  logic [CR_W-1:0]  credit_used;

  // Handshakes, credit check and RAM port drive.
  // A slot is reserved for every inflight read/write; a slot freed by this
  // cycle's pop may be reused immediately, which sustains one request per cycle.
  assign pop         = rsp_valid & rsp_ready;
  assign push        = inflight_q;
  assign credit_used = CR_W'(count_q) + CR_W'(inflight_q) - CR_W'(pop);
  assign req_ready   = rst_n & (credit_used < DEPTH_CR);
  assign issue       = req_valid & req_ready;

  assign ram_addr = req_addr;
  assign ram_din  = req_wdata;
  assign ram_we   = issue & req_we;

  // Response outputs come straight from the head register of the FIFO.
  assign rsp_valid = (count_q != '0);
  assign rsp_we    = buf_q[rd_ptr_q].we;
  assign rsp_rdata = buf_q[rd_ptr_q].data;

  // Next-state computation for the inflight tracker and the response FIFO.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    buf_d      = buf_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = issue;
    we_d       = issue ? req_we : we_q;

    // The RAM is write-through, so dout carries the written word for writes.
    if (push) begin
      buf_d[wr_ptr_q] = '{we: we_q, data: ram_dout};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // State registers; reset discards inflight and buffered responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the buffer entries are reset because rsp_we/rsp_rdata read the head entry and must be 0 out of reset.
      for (int i = 0; i < RSP_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      we_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      buf_q      <= buf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      we_q       <= we_d;
    end
  end

  // The credit rule must make a push into a full buffer impossible.
  always @(posedge clk) begin
    if (rst_n) begin
      a_no_overflow: assert (!(push && (count_q == DEPTH_CNT)));
    end
  end

endmodule

// File: tb/tb_or1k_dpram_port_requester.sv
// Self-checking bench for or1k_dpram_port_requester. Includes a behavioural
// write-through RAM with registered dout, a shadow memory that predicts read
// data at issue time, and an in-order scoreboard queue of expected responses.
module tb_or1k_dpram_port_requester;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_we;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_din, ram_dout;

  typedef struct packed {
    logic          we;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] mem     [1 << AW];
  logic [DW-1:0] ref_mem [1 << AW];

  int errors = 0;
  int checks = 0;
  int issues = 0;
  int pops   = 0;

  always #5 clk = ~clk;

  or1k_dpram_port_requester #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_rdata(rsp_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // Write-through RAM port with registered output; not touched by rst_n.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= ram_we ? ram_din : mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
  endtask

  // One clock: sample settled handshakes, update scoreboard, advance to next negedge.
  task automatic tick();
    exp_t e;
    #1;
    if (rsp_valid && rsp_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        chk("rsp_with_empty_scoreboard", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("rsp", 64'({rsp_we, rsp_rdata}), 64'({e.we, e.data}));
      end
    end
    if (req_valid && req_ready) begin
      issues++;
      if (req_we) begin
        exp_q.push_back('{we: 1'b1, data: req_wdata});
        ref_mem[req_addr] = req_wdata;
      end else begin
        exp_q.push_back('{we: 1'b0, data: ref_mem[req_addr]});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    drive(1'b0, 1'b0, '0, '0);
    rsp_ready = 1'b1;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    tick();
    tick();
    chk("idle_rsp_valid", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] held_data;
    logic          held_we;
    int            p0, i0, n;

    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = 32'(i) * 32'h11;
      ref_mem[i] = 32'(i) * 32'h11;
    end

    // 1: reset gates req_ready and ram_we even with a valid write pending.
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    drive(1'b1, 1'b1, 10'h3A5, 32'h1234_5678);
    @(negedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_ram_we",    64'(ram_we),    64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_we",    64'(rsp_we),    64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);

    // 2: write then read of the same address; first response at issue + 2.
    drive(1'b1, 1'b1, 10'h3A5, 32'hDEAD_BEEF);
    #1;
    chk("wr_ram_we", 64'(ram_we), 64'd1);
    tick();
    drive(1'b1, 1'b0, 10'h3A5, 32'h0);
    #1;
    chk("lat_n1_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rd_ram_we", 64'(ram_we), 64'd0);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    #1;
    chk("lat_n2_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("raw_first_rsp", 64'({rsp_we, rsp_rdata}), 64'({1'b1, 32'hDEAD_BEEF}));
    p0 = pops;
    tick();
    #1;
    chk("raw_second_rsp", 64'({rsp_we, rsp_rdata}), 64'({1'b0, 32'hDEAD_BEEF}));
    drain(20);
    chk("raw_pop_count", 64'(pops - p0), 64'd2);

    // 3: 16 back-to-back reads with rsp_ready=1, one response per cycle.
    p0 = pops;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, AW'(i), '0);
      #1;
      chk($sformatf("stream_ready_%0d", i), 64'(req_ready), 64'd1);
      tick();
    end
    drive(1'b0, 1'b0, '0, '0);
    tick();
    tick();
    chk("stream_pop_count", 64'(pops - p0), 64'd16);
    chk("stream_sb_empty", 64'(exp_q.size()), 64'd0);

    // 4: stalled consumer: exactly DEPTH issues, then stable head.
    i0 = issues;
    rsp_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b0, AW'(10'h20 + k), '0);
      tick();
    end
    chk("stall_issue_count", 64'(issues - i0), 64'(DEPTH));
    #1;
    chk("stall_req_ready", 64'(req_ready), 64'd0);
    chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("stall_head", 64'({rsp_we, rsp_rdata}), 64'({exp_q[0].we, exp_q[0].data}));
    held_we   = rsp_we;
    held_data = rsp_rdata;
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      chk("stall_stable", 64'({rsp_we, rsp_rdata}), 64'({held_we, held_data}));
    end
    p0 = pops;
    drain(20);
    chk("stall_pop_count", 64'(pops - p0), 64'(DEPTH));

    // 5: random request mix against random backpressure.
    i0 = issues;
    n  = 0;
    while (issues - i0 < 2000 && n < 20000) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      if ((issues - i0) < 2000) begin
        drive($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
              AW'($urandom_range(0, 15)), $urandom);
      end
      tick();
      n++;
    end
    chk("rand_issue_count", 64'(issues - i0), 64'd2000);
    drain(50);

    // 6: reset one cycle after a write issue discards the response only.
    drive(1'b1, 1'b1, 10'h155, 32'hA5A5_0F0F);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("midrst_release_ready", 64'(req_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      #1;
      chk("midrst_no_stale", 64'(rsp_valid), 64'd0);
    end
    drive(1'b1, 1'b0, 10'h155, '0);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    tick();
    #1;
    chk("midrst_write_landed", 64'({rsp_we, rsp_rdata}), 64'({1'b0, 32'hA5A5_0F0F}));
    drain(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
